rat_io_ctrl: RTL and testbench

Peripheral I/O stage directly downstream and upstream of the RAT MCU on the Basys3 board. It decodes the MCU's `PORT_ID` / `OUT_PORT` / `IO_STRB` output bus into latched LED and seven-segment registers, and drives a 2-digit hex display scan. It returns switch data on `IN_PORT` and converts a debounced push-button into a sticky `INT_CU` request that stays asserted until software acknowledges it.

---
 rtl/rat_io_pkg.sv | 30 +++
 rtl/hex_to_sseg.sv | 31 +++
 rtl/rat_io_ctrl.sv | 137 +++++++++++++
 tb/tb_rat_io_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_io_pkg.sv
// Shared constants for the RAT MCU peripheral I/O stage: port map and
// display anode encoding.
package rat_io_pkg;

  localparam logic [7:0] LEDS_ID     = 8'h40;
  localparam logic [7:0] SSEG_ID     = 8'h81;
  localparam logic [7:0] INT_ACK_ID  = 8'hF0;
  localparam logic [7:0] SWITCHES_ID = 8'h20;
  localparam logic [7:0] INT_STAT_ID = 8'hF1;

  localparam logic [3:0] AN_IDLE = 4'b1111;

  typedef enum logic {
    DIGIT_LO = 1'b0,
    DIGIT_HI = 1'b1
  } digit_e;

  // Only the two low digits are ever lit; the upper anodes stay at idle.
  function automatic logic [3:0] an_for_digit(input digit_e digit);
    logic [3:0] an;
    an = AN_IDLE;
    if (digit == DIGIT_HI) begin
      an[1] = 1'b0;
    end else begin
      an[0] = 1'b0;
    end
    return an;
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to seven-segment decoder.
// Output bit order is {g,f,e,d,c,b,a}, active-low.
module hex_to_sseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/rat_io_ctrl.sv
// RAT MCU I/O stage: output-port decode to LED/7-seg registers, switch
// read-back, debounced push-button interrupt and 2-digit display scan.
module rat_io_ctrl
  import rat_io_pkg::*;
#(
  parameter int DB_CYCLES = 50000,
  parameter int SCAN_BITS = 17
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] OUT_PORT,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  input  logic [7:0] SWITCHES,
  input  logic       BTN_INT,
  output logic [7:0] IN_PORT,
  output logic       INT_CU,
  output logic [7:0] LEDS,
  output logic [6:0] SEGMENTS,
  output logic [3:0] AN
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [7:0]           sw_sync;
  logic [1:0]           btn_sync_reg;
  logic [DB_W-1:0]      db_cnt_reg, db_cnt_next;
  logic                 db_reg, db_next;
  logic                 db_dly_reg;
  logic                 int_pend_reg, int_pend_next;
  logic [7:0]           leds_reg;
  logic [7:0]           sseg_reg;
  logic [SCAN_BITS-1:0] scan_reg;
  logic [3:0]           an_reg, an_next;
  logic [6:0]           seg_reg, seg_next;
  logic                 wr_leds, wr_sseg, wr_ack, int_set;
  digit_e               digit_sel;
  logic [3:0]           digit_nibble;

  // Each switch bit gets its own two-stage synchronizer.
  for (genvar gi = 0; gi < 8; gi++) begin : g_sw_sync
    logic [1:0] sync_reg;
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync_reg <= 2'b00;
      end else begin
        sync_reg <= {sync_reg[0], SWITCHES[gi]};
      end
    end
    assign sw_sync[gi] = sync_reg[1];
  end

  assign wr_leds = IO_STRB && (PORT_ID == LEDS_ID);
  assign wr_sseg = IO_STRB && (PORT_ID == SSEG_ID);
  assign wr_ack  = IO_STRB && (PORT_ID == INT_ACK_ID);

  // Any disagreement between sync level and db that is not sustained for
  // DB_CYCLES cycles leaves db alone; agreement always clears the count.
  always_comb begin
    db_cnt_next = '0;
    db_next     = db_reg;
    if (btn_sync_reg[1] != db_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        db_next = btn_sync_reg[1];
      end else begin
        db_cnt_next = db_cnt_reg + 1'b1;
      end
    end
  end

  // A new debounced press outranks a simultaneous acknowledge.
  assign int_set = db_reg && !db_dly_reg;

  always_comb begin
    int_pend_next = int_pend_reg;
    if (int_set) begin
      int_pend_next = 1'b1;
    end else if (wr_ack) begin
      int_pend_next = 1'b0;
    end
  end

  assign digit_sel    = digit_e'(scan_reg[SCAN_BITS-1]);
  assign digit_nibble = (digit_sel == DIGIT_HI) ? sseg_reg[7:4] : sseg_reg[3:0];
  assign an_next      = an_for_digit(digit_sel);

  hex_to_sseg u_hex_to_sseg (
    .hex (digit_nibble),
    .seg (seg_next)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_sync_reg <= 2'b00;
      db_cnt_reg   <= '0;
      db_reg       <= 1'b0;
      db_dly_reg   <= 1'b0;
      int_pend_reg <= 1'b0;
      leds_reg     <= 8'h00;
      sseg_reg     <= 8'h00;
      scan_reg     <= '0;
      an_reg       <= an_for_digit(DIGIT_LO);
      seg_reg      <= 7'b1000000;
    end else begin
      btn_sync_reg <= {btn_sync_reg[0], BTN_INT};
      db_cnt_reg   <= db_cnt_next;
      db_reg       <= db_next;
      db_dly_reg   <= db_reg;
      int_pend_reg <= int_pend_next;
      if (wr_leds) begin
        leds_reg <= OUT_PORT;
      end
      if (wr_sseg) begin
        sseg_reg <= OUT_PORT;
      end
      scan_reg <= scan_reg + 1'b1;
      an_reg   <= an_next;
      seg_reg  <= seg_next;
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      SWITCHES_ID: IN_PORT = sw_sync;
      INT_STAT_ID: IN_PORT = {7'b0000000, int_pend_reg};
      default:     IN_PORT = 8'h00;
    endcase
  end

  assign INT_CU   = int_pend_reg;
  assign LEDS     = leds_reg;
  assign AN       = an_reg;
  assign SEGMENTS = seg_reg;

endmodule

// File: tb/tb_rat_io_ctrl.sv
// Randomized scoreboard bench for rat_io_ctrl: stimulus queues timed
// expectations from a cycle-level model, a monitor compares on negedges.
module tb_rat_io_ctrl;

  localparam int DB       = 8;
  localparam int SB       = 4;
  localparam int SCAN_LEN = 1 << SB;
  localparam int HALF     = SCAN_LEN / 2;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum int {K_LEDS, K_INT, K_IN, K_AN, K_SEG} kind_e;
  typedef struct {
    int         cyc;
    kind_e      kind;
    logic [7:0] exp;
    string      name;
  } chk_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] OUT_PORT = 8'h00;
  logic [7:0] PORT_ID = 8'h00;
  logic       IO_STRB = 1'b0;
  logic [7:0] SWITCHES = 8'h00;
  logic       BTN_INT = 1'b0;
  logic [7:0] IN_PORT;
  logic       INT_CU;
  logic [7:0] LEDS;
  logic [6:0] SEGMENTS;
  logic [3:0] AN;

  int   cyc = 0;
  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   end_req = 1'b0;
  bit   end_ack = 1'b0;

  logic [7:0] leds_m = 8'h00;
  logic [7:0] sw_m   = 8'h00;
  logic       int_m  = 1'b0;

  rat_io_ctrl #(.DB_CYCLES(DB), .SCAN_BITS(SB)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .OUT_PORT (OUT_PORT),
    .PORT_ID  (PORT_ID),
    .IO_STRB  (IO_STRB),
    .SWITCHES (SWITCHES),
    .BTN_INT  (BTN_INT),
    .IN_PORT  (IN_PORT),
    .INT_CU   (INT_CU),
    .LEDS     (LEDS),
    .SEGMENTS (SEGMENTS),
    .AN       (AN)
  );

  always #5 CLK = ~CLK;

  // Edges seen since reset was last released.
  always @(posedge CLK) cyc <= RST_N ? cyc + 1 : 0;

  task automatic expect_at(input int c, input kind_e k, input logic [7:0] v, input string nm);
    chk_t e;
    e.cyc  = c;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] read_model(input logic [7:0] id);
    if (id == 8'h20) return sw_m;
    if (id == 8'hF1) return {7'b0000000, int_m};
    return 8'h00;
  endfunction

  // Monitor: compare every queued expectation due this cycle.
  initial begin
    int i;
    logic [7:0] act;
    forever begin
      @(negedge CLK);
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc <= cyc) begin
          case (sb[i].kind)
            K_LEDS:  act = LEDS;
            K_INT:   act = {7'b0000000, INT_CU};
            K_IN:    act = IN_PORT;
            K_AN:    act = {4'b0000, AN};
            default: act = {1'b0, SEGMENTS};
          endcase
          checks++;
          if (sb[i].cyc < cyc) begin
            errors++;
            $display("FAIL %s missed at cyc %0d (due %0d)", sb[i].name, cyc, sb[i].cyc);
          end else if (act !== sb[i].exp) begin
            errors++;
            $display("FAIL %s cyc %0d actual %02h expected %02h", sb[i].name, cyc, act, sb[i].exp);
          end else begin
            $display("ok   %s cyc %0d value %02h", sb[i].name, cyc, act);
          end
          sb.delete(i);
        end else begin
          i++;
        end
      end
      if (end_req && !end_ack) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL scoreboard_drain actual %0d pending expected 0", sb.size());
        end
        end_ack = 1'b1;
      end
    end
  end

  task automatic io_write(input logic [7:0] id, input logic [7:0] d, input logic strb);
    int n;
    n = cyc;
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = strb;
    expect_at(n, K_IN, read_model(id), "in_port");
    if (strb && id == 8'h40) leds_m = d;
    if (strb && id == 8'hF0) begin
      int_m = 1'b0;
      expect_at(n + 1, K_INT, 8'h00, "int_ack");
    end
    expect_at(n + 1, K_LEDS, leds_m, "leds");
    tick;
    IO_STRB = 1'b0;
  endtask

  task automatic sw_read(input logic [7:0] v);
    int n;
    n = cyc;
    SWITCHES = v;
    PORT_ID  = 8'h20;
    IO_STRB  = 1'b0;
    expect_at(n, K_IN, sw_m, "sw_now");
    expect_at(n + 1, K_IN, sw_m, "sw_lag1");
    expect_at(n + 2, K_IN, v, "sw_lag2");
    sw_m = v;
    repeat (3) tick;
  endtask

  // A press registers only if held for at least DB cycles; the request
  // appears DB+3 edges after the press.
  task automatic press(input int len);
    int n;
    bit req;
    n = cyc;
    req = (len >= DB);
    BTN_INT = 1'b1;
    expect_at(n + DB + 2, K_INT, {7'b0000000, int_m}, "int_before");
    expect_at(n + DB + 3, K_INT, {7'b0000000, int_m | req}, req ? "int_rise" : "int_glitch");
    repeat (len) tick;
    BTN_INT = 1'b0;
    if (req) int_m = 1'b1;
    repeat (DB + 6) tick;
  endtask

  task automatic display_check(input logic [7:0] v);
    int w;
    int s;
    io_write(8'h81, v, 1'b1);
    w = cyc;
    for (int k = w + 1; k <= w + 2 * SCAN_LEN + 4; k++) begin
      s = (k - 1) % SCAN_LEN;
      expect_at(k, K_AN, (s >= HALF) ? 8'h0D : 8'h0E, "an");
      expect_at(k, K_SEG, {1'b0, HEX_TAB[(s >= HALF) ? v[7:4] : v[3:0]]}, "seg");
    end
    repeat (2 * SCAN_LEN + 5) tick;
  endtask

  task automatic drain;
    for (int t = 0; t < 300 && sb.size() != 0; t++) tick;
  endtask

  initial begin
    int n;
    logic [7:0] id;
    logic [7:0] ids [6];
    ids = '{8'h40, 8'h81, 8'h41, 8'h80, 8'hF1, 8'h00};

    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    tick;
    expect_at(cyc, K_LEDS, 8'h00, "rst_leds");
    expect_at(cyc, K_INT, 8'h00, "rst_int");
    expect_at(cyc, K_AN, 8'h0E, "rst_an");

    io_write(8'h40, 8'h3C, 1'b1);
    io_write(8'h40, 8'hC3, 1'b0);
    io_write(8'h41, 8'h99, 1'b1);
    sw_read(8'h96);
    io_write(8'h21, 8'h00, 1'b0);

    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 2))
        0: begin
          id = ids[$urandom_range(0, 5)];
          if (id == 8'h00) id = 8'($urandom_range(0, 255));
          io_write(id, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        1: sw_read(8'($urandom_range(0, 255)));
        default: io_write(8'($urandom_range(0, 255)), 8'h00, 1'b0);
      endcase
    end

    press(5);
    press(DB);
    io_write(8'hF1, 8'h00, 1'b0);
    io_write(8'hF0, 8'h5A, 1'b1);
    io_write(8'hF1, 8'h00, 1'b0);
    for (int r = 0; r < 3; r++) begin
      press(int'($urandom_range(1, DB - 1)));
      press(int'($urandom_range(DB, DB + 12)));
      io_write(8'hF1, 8'h00, 1'b0);
      io_write(8'hF0, 8'($urandom_range(0, 255)), 1'b1);
    end

    // Long hold: one request only, ack mid-hold stays acknowledged.
    n = cyc;
    BTN_INT = 1'b1;
    expect_at(n + DB + 3, K_INT, 8'h01, "hold_rise");
    repeat (30) tick;
    io_write(8'hF0, 8'h00, 1'b1);
    repeat (69) tick;
    expect_at(cyc, K_INT, 8'h00, "hold_no_repeat");
    BTN_INT = 1'b0;
    repeat (DB + 6) tick;
    expect_at(cyc, K_INT, 8'h00, "release_no_req");
    tick;

    // Ack landing on the same edge as a new debounced press.
    press(DB + 4);
    n = cyc;
    BTN_INT = 1'b1;
    repeat (DB + 2) tick;
    PORT_ID = 8'hF0;
    IO_STRB = 1'b1;
    expect_at(n + DB + 3, K_INT, 8'h01, "ack_vs_set");
    tick;
    IO_STRB = 1'b0;
    repeat (10) tick;
    BTN_INT = 1'b0;
    repeat (DB + 6) tick;
    expect_at(cyc, K_INT, 8'h01, "ack_vs_set_hold");
    tick;
    io_write(8'hF0, 8'h00, 1'b1);

    display_check(8'h7E);
    display_check(8'($urandom_range(0, 255)));

    // Asynchronous reset mid-scan with state loaded.
    io_write(8'h40, 8'hA5, 1'b1);
    sw_read(8'h5A);
    press(DB + 2);
    drain();
    for (int t = 0; t < 2 * SCAN_LEN && ((cyc - 1) % SCAN_LEN) < HALF + 1; t++) tick;
    n = cyc;
    expect_at(n, K_LEDS, 8'h00, "arst_leds");
    expect_at(n, K_INT, 8'h00, "arst_int");
    expect_at(n, K_AN, 8'h0E, "arst_an");
    expect_at(n, K_SEG, 8'h40, "arst_seg");
    expect_at(n, K_IN, 8'h00, "arst_in_sw");
    RST_N = 1'b0;
    leds_m = 8'h00;
    int_m  = 1'b0;
    sw_m   = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    tick;
    expect_at(cyc, K_LEDS, 8'h00, "post_rst_leds");
    expect_at(cyc, K_AN, 8'h0E, "post_rst_an");
    expect_at(cyc, K_IN, 8'h00, "post_rst_in");
    drain();

    end_req = 1'b1;
    for (int t = 0; t < 10 && !end_ack; t++) @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
